// File: rtl/tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tour_cmd_seq
//
// Turns a knight's-tour solution into a stream of motion commands for the
// command processor. A tour is started by a one-cycle start_tour pulse. The
// block then launches the solver and waits for it to finish. After that it
// walks the solution one move at a time. Each knight move becomes two
// commands: a vertical leg (OP_MOVE) followed by a horizontal leg
// (OP_FANFARE). Each command is handed over with the command processor's
// cmd_rdy / clr_cmd_rdy handshake. The block then waits for send_resp before
// it issues the next command. Outside a tour, UART commands pass straight
// through to the command processor.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start_tour        1-cycle request to run a tour (honoured only in IDLE)
//   tour_go           1-cycle launch pulse to the tour solver
//   tour_done         1-cycle completion pulse from the solver
//   indx[4:0]         move index presented to the solver
//   move[7:0]         one-hot move returned by the solver for indx
//   cmd_uart[15:0]    command from the UART wrapper
//   cmd_rdy_uart      UART command valid
//   clr_cmd_rdy_uart  clear back to the UART wrapper
//   cmd[15:0]         command to the command processor
//   cmd_rdy           command valid to the command processor
//   clr_cmd_rdy       command processor has taken cmd
//   send_resp         command processor has finished executing cmd
//   resp[7:0]         8'hA5 while the tour still has moves left, else 8'h5A
//   err               sticky flag: a move that was not one-hot was read
//
// Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
// ---------------------------------------------------------------------------
module tour_cmd_seq #(
  parameter int         NUM_MOVES  = 24,
  parameter logic [3:0] OP_MOVE    = 4'h2,
  parameter logic [3:0] OP_FANFARE = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  output logic        tour_go,
  input  logic        tour_done,
  output logic [4:0]  indx,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_uart,
  input  logic        cmd_rdy_uart,
  output logic        clr_cmd_rdy_uart,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        err
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_BUSY = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    SOLVE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] cmd_q;
  logic        rdy_q;

  logic        go_set;
  logic        load_leg;
  logic        leg_horz;
  logic        rdy_drop;
  logic        indx_clr;
  logic        indx_inc;

  // True when exactly one bit of the move is set.
  function automatic logic is_onehot(input logic [7:0] m);
    return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
  endfunction

  // Vertical leg of a knight move. A move that is not one-hot falls through
  // to the default case: heading N, zero squares.
  function automatic logic [15:0] vert_leg(input logic [7:0] m);
    logic [7:0] hd;
    logic [3:0] sq;
    hd = HEAD_N;
    sq = 4'd0;
    case (m)
      8'h01, 8'h02: begin hd = HEAD_N; sq = 4'd2; end
      8'h04, 8'h40: begin hd = HEAD_N; sq = 4'd1; end
      8'h08, 8'h80: begin hd = HEAD_S; sq = 4'd1; end
      8'h10, 8'h20: begin hd = HEAD_S; sq = 4'd2; end
      default:      begin hd = HEAD_N; sq = 4'd0; end
    endcase
    return {OP_MOVE, hd, sq};
  endfunction

  // Horizontal leg of a knight move. The fallback is the same as for the
  // vertical leg.
  function automatic logic [15:0] horz_leg(input logic [7:0] m);
    logic [7:0] hd;
    logic [3:0] sq;
    hd = HEAD_N;
    sq = 4'd0;
    case (m)
      8'h01, 8'h10: begin hd = HEAD_W; sq = 4'd1; end
      8'h02, 8'h20: begin hd = HEAD_E; sq = 4'd1; end
      8'h04, 8'h08: begin hd = HEAD_W; sq = 4'd2; end
      8'h40, 8'h80: begin hd = HEAD_E; sq = 4'd2; end
      default:      begin hd = HEAD_N; sq = 4'd0; end
    endcase
    return {OP_FANFARE, hd, sq};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the output mux.
  //
  // In VERT/HORZ, rdy_q is always low on the first cycle, because it is
  // dropped on the way out of the previous leg. That first cycle samples
  // move (indx has just settled) and loads the command. The cycle after
  // that raises cmd_rdy. From then on, only clr_cmd_rdy moves the state
  // on. A send_resp in the same cycle is ignored, because the WAIT state
  // is not active yet.
  always_comb begin
    state_next       = state;
    go_set           = 1'b0;
    load_leg         = 1'b0;
    leg_horz         = 1'b0;
    rdy_drop         = 1'b0;
    indx_clr         = 1'b0;
    indx_inc         = 1'b0;
    cmd              = cmd_q;
    cmd_rdy          = rdy_q;
    clr_cmd_rdy_uart = 1'b0;
    resp             = RESP_DONE;

    case (state)
      IDLE: begin
        cmd              = cmd_uart;
        cmd_rdy          = cmd_rdy_uart;
        clr_cmd_rdy_uart = clr_cmd_rdy;
        if (start_tour) begin
          go_set     = 1'b1;
          indx_clr   = 1'b1;
          state_next = SOLVE;
        end
      end

      SOLVE: begin
        if (tour_done) begin
          state_next = VERT;
        end
      end

      VERT: begin
        resp = RESP_BUSY;
        if (!rdy_q) begin
          load_leg = 1'b1;
        end else if (clr_cmd_rdy) begin
          rdy_drop   = 1'b1;
          state_next = WAIT_V;
        end
      end

      WAIT_V: begin
        resp = RESP_BUSY;
        if (send_resp) begin
          state_next = HORZ;
        end
      end

      HORZ: begin
        resp     = RESP_BUSY;
        leg_horz = 1'b1;
        if (!rdy_q) begin
          load_leg = 1'b1;
        end else if (clr_cmd_rdy) begin
          rdy_drop   = 1'b1;
          state_next = WAIT_H;
        end
      end

      WAIT_H: begin
        // The last move's horizontal leg reports "done" while it waits.
        resp = (indx == LAST_INDX) ? RESP_DONE : RESP_BUSY;
        if (send_resp) begin
          if (indx == LAST_INDX) begin
            indx_clr   = 1'b1;
            state_next = IDLE;
          end else begin
            indx_inc   = 1'b1;
            state_next = VERT;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: launch pulse, move index, registered command,
  // command-valid flag and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tour_go <= 1'b0;
      indx    <= 5'd0;
      cmd_q   <= 16'h0000;
      rdy_q   <= 1'b0;
      err     <= 1'b0;
    end else begin
      tour_go <= go_set;

      if (indx_clr) begin
        indx <= 5'd0;
      end else if (indx_inc) begin
        indx <= indx + 5'd1;
      end

      if (load_leg) begin
        cmd_q <= leg_horz ? horz_leg(move) : vert_leg(move);
        rdy_q <= 1'b1;
        if (!is_onehot(move)) begin
          err <= 1'b1;
        end
      end else if (rdy_drop) begin
        rdy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_tour_cmd_seq
//
// Testbench for tour_cmd_seq. It models the tour solver as a table of moves
// indexed by indx. Every command is checked against a reference that works
// from knight displacements: the vertical and horizontal offset of each
// move bit. The heading and the square count come from the sign and the
// size of each offset.
// ---------------------------------------------------------------------------
module tb_tour_cmd_seq;

  localparam int NUM_MOVES = 24;

  // Knight displacement for each move bit: +dy is north, +dx is east.
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, 1, -1};
  localparam int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic        tour_go;
  logic        tour_done;
  logic [4:0]  indx;
  logic [7:0]  move;
  logic [15:0] cmd_uart;
  logic        cmd_rdy_uart;
  logic        clr_cmd_rdy_uart;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        err;

  logic [7:0]  moves [NUM_MOVES];
  int          tests_run;
  int          fail_count;
  int          rdy_rises;
  logic        prev_rdy;
  logic        model_err;

  tour_cmd_seq #(
    .NUM_MOVES (NUM_MOVES),
    .OP_MOVE   (4'h2),
    .OP_FANFARE(4'h3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_tour      (start_tour),
    .tour_go         (tour_go),
    .tour_done       (tour_done),
    .indx            (indx),
    .move            (move),
    .cmd_uart        (cmd_uart),
    .cmd_rdy_uart    (cmd_rdy_uart),
    .clr_cmd_rdy_uart(clr_cmd_rdy_uart),
    .cmd             (cmd),
    .cmd_rdy         (cmd_rdy),
    .clr_cmd_rdy     (clr_cmd_rdy),
    .send_resp       (send_resp),
    .resp            (resp),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The solver answers combinationally for the index it is given.
  always_comb begin
    move = 8'h00;
    if (int'(indx) < NUM_MOVES) move = moves[indx];
  end

  // Counts rising edges of cmd_rdy, i.e. separate command offers.
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rdy_rises = rdy_rises + 1;
    prev_rdy = cmd_rdy;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz);
    int k;
    int d;
    logic [7:0] hd;
    logic [3:0] op;
    op = horiz ? 4'h3 : 4'h2;
    if ($countones(m) != 1) return {op, 8'h00, 4'h0};
    k = 0;
    for (int b = 0; b < 8; b++) if (m[b]) k = b;
    d = horiz ? DX[k] : DY[k];
    if (horiz) hd = (d < 0) ? 8'h3F : 8'hBF;
    else       hd = (d > 0) ? 8'h00 : 8'h7F;
    return {op, hd, 4'(d < 0 ? -d : d)};
  endfunction

  function automatic logic [7:0] rand_onehot();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(0, 7);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic st, input logic td, input logic [15:0] cu,
                               input logic cru, input logic clr, input logic sr);
    start_tour   = st;
    tour_done    = td;
    cmd_uart     = cu;
    cmd_rdy_uart = cru;
    clr_cmd_rdy  = clr;
    send_resp    = sr;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic sendResp();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  // Runs one leg. It waits for the offer, checks it, holds for a few
  // cycles, then clears it. It leaves the DUT in the matching WAIT state.
  task automatic doLeg(input int i, input bit horiz, input bit rnd,
                       input bit poke_start, output bit ok);
    int n;
    int hold;
    bit both;
    ok = 1'b0;
    n  = 0;
    while (cmd_rdy !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (cmd_rdy !== 1'b1) begin
      checkOutput("rdy_timeout", 16'(cmd_rdy), 16'h0001);
      return;
    end
    if ($countones(moves[i]) != 1) model_err = 1'b1;
    checkOutput(horiz ? "horz_cmd" : "vert_cmd", cmd, model_cmd(moves[i], horiz));
    checkOutput("leg_indx", 16'(indx), 16'(i));
    checkOutput("leg_resp", 16'(resp), 16'h00A5);
    checkOutput("leg_err", 16'(err), 16'(model_err));

    hold = rnd ? int'($urandom_range(0, 2)) : 0;
    if (poke_start) hold = hold + 1;
    both = rnd && ($urandom_range(0, 3) == 0);
    for (int h = 0; h < hold; h++) begin
      start_tour = poke_start && (h == 0);
      tick();
      start_tour = 1'b0;
      checkOutput("rdy_hold", 16'(cmd_rdy), 16'h0001);
      checkOutput("go_ignored", 16'(tour_go), 16'h0000);
    end

    clr_cmd_rdy = 1'b1;
    send_resp   = both;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    checkOutput("rdy_drop", 16'(cmd_rdy), 16'h0000);
    // A send_resp that came with the clear must not move the DUT on. If it
    // did, a new offer would appear within these cycles.
    for (int w = 0; w < 2 + int'($urandom_range(0, 1)); w++) begin
      tick();
      checkOutput("wait_quiet", 16'(cmd_rdy), 16'h0000);
    end
    checkOutput("wait_resp", 16'(resp),
                (horiz && i == NUM_MOVES - 1) ? 16'h005A : 16'h00A5);
    ok = 1'b1;
  endtask

  // Starts a tour and walks it. If abort_at is a valid index, it stops in
  // WAIT_V of that move and leaves the reset to the caller.
  task automatic runTour(input bit rnd, input int poke_at, input int abort_at);
    bit ok;
    rdy_rises = 0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    start_tour = 1'b0;
    checkOutput("go_pulse", 16'(tour_go), 16'h0001);
    checkOutput("go_indx", 16'(indx), 16'h0000);
    tick();
    checkOutput("go_drop", 16'(tour_go), 16'h0000);
    for (int s = 0; s < 2 + int'($urandom_range(0, 3)); s++) begin
      cmd_rdy_uart = 1'b1;
      clr_cmd_rdy  = 1'b1;
      #1;
      checkOutput("solve_rdy", 16'(cmd_rdy), 16'h0000);
      checkOutput("solve_clr_uart", 16'(clr_cmd_rdy_uart), 16'h0000);
      checkOutput("solve_resp", 16'(resp), 16'h005A);
      tick();
    end
    cmd_rdy_uart = 1'b0;
    clr_cmd_rdy  = 1'b0;
    tour_done    = 1'b1;
    tick();
    tour_done    = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      doLeg(i, 1'b0, rnd, i == poke_at, ok);
      if (!ok) return;
      if (i == abort_at) return;
      sendResp();
      doLeg(i, 1'b1, rnd, 1'b0, ok);
      if (!ok) return;
      sendResp();
    end
    checkOutput("end_indx", 16'(indx), 16'h0000);
    checkOutput("end_resp", 16'(resp), 16'h005A);
    checkOutput("end_rdy", 16'(cmd_rdy), 16'h0000);
    checkOutput("rdy_count", 16'(rdy_rises), 16'(2 * NUM_MOVES));
    checkOutput("end_err", 16'(err), 16'(model_err));
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rdy_rises  = 0;
    prev_rdy   = 1'b0;
    model_err  = 1'b0;
    rst_n      = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_onehot();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Values while reset is held.
    tick();
    checkOutput("rst_go", 16'(tour_go), 16'h0000);
    checkOutput("rst_rdy", 16'(cmd_rdy), 16'h0000);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkOutput("rst_clr_uart", 16'(clr_cmd_rdy_uart), 16'h0000);
    checkOutput("rst_resp", 16'(resp), 16'h005A);
    checkOutput("rst_err", 16'(err), 16'h0000);
    checkOutput("rst_indx", 16'(indx), 16'h0000);
    rst_n = 1'b1;
    tick();

    // IDLE passthrough from the UART side.
    applyStimulus(1'b0, 1'b0, 16'h2003, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("pass_cmd", cmd, 16'h2003);
    checkOutput("pass_rdy", 16'(cmd_rdy), 16'h0001);
    checkOutput("pass_clr", 16'(clr_cmd_rdy_uart), 16'h0001);
    tick();
    checkOutput("pass_go", 16'(tour_go), 16'h0000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      #1;
      checkOutput("pass_rand_cmd", cmd, cmd_uart);
      checkOutput("pass_rand_rdy", 16'(cmd_rdy), 16'(cmd_rdy_uart));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Tour with prompt handshakes. Move 0 is 8'h04 and move 5 is not
    // one-hot. A start_tour poke arrives during VERT of move 5.
    moves[0] = 8'h04;
    moves[5] = 8'h00;
    runTour(1'b0, 5, -1);
    tick();

    // Reset clears the sticky error. Then run a random tour with random
    // handshake timing.
    rst_n = 1'b0;
    model_err = 1'b0;
    tick();
    checkOutput("err_cleared", 16'(err), 16'h0000);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_onehot();
    runTour(1'b1, -1, -1);
    tick();

    // Reset in WAIT_V at move 10.
    for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_onehot();
    runTour(1'b1, -1, 10);
    rst_n = 1'b0;
    model_err = 1'b0;
    #1;
    checkOutput("abort_rdy", 16'(cmd_rdy), 16'h0000);
    checkOutput("abort_indx", 16'(indx), 16'h0000);
    checkOutput("abort_resp", 16'(resp), 16'h005A);
    checkOutput("abort_cmd", cmd, 16'h0000);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("abort_idle_cmd", cmd, 16'h1234);
    checkOutput("abort_idle_rdy", 16'(cmd_rdy), 16'h0001);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequences a knight's-tour solution into motion commands for the command processor.
- Launches the tour solver, waits for its done pulse, then reads the 24 solution moves by index.
- Each move is split into a vertical command followed by a horizontal command; each command is handed over through the command processor's ready/clear handshake.
- Outside a tour, passes UART commands straight through to the command processor.

Parameters:
- NUM_MOVES, 24, number of moves read out of the solver (indx 0..NUM_MOVES-1).
- OP_MOVE, 4'h2, opcode for the vertical leg of each move.
- OP_FANFARE, 4'h3, opcode for the horizontal leg of each move.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start_tour  input  1  1-cycle pulse requesting a tour
- tour_go  output  1  1-cycle pulse to launch the solver
- tour_done  input  1  solver 1-cycle completion pulse
- indx  output  5  move index presented to the solver
- move  input  8  one-hot move returned by the solver for indx
- cmd_uart  input  16  command from UART wrapper
- cmd_rdy_uart  input  1  UART command valid
- clr_cmd_rdy_uart  output  1  clear to UART wrapper
- cmd  output  16  command to command processor
- cmd_rdy  output  1  command valid to command processor
- clr_cmd_rdy  input  1  command processor accepted cmd
- send_resp  input  1  command processor finished executing cmd
- resp  output  8  response byte: 8'hA5 mid-tour, 8'h5A otherwise
- err  output  1  sticky: a non-one-hot move was read

Behaviour:
- Reset: state IDLE, indx=0, tour_go=0, cmd_rdy=0, cmd=16'h0000, clr_cmd_rdy_uart=0, resp=8'h5A, err=0.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode table: bit → vertical leg, horizontal leg.
  - 0: N2, W1
  - 1: N2, E1
  - 2: N1, W2
  - 3: S1, W2
  - 4: S2, W1
  - 5: S2, E1
  - 6: N1, E2
  - 7: S1, E2
- Vertical leg uses OP_MOVE; horizontal leg uses OP_FANFARE.
- move not one-hot: both legs are issued with squares=0 and heading N; err sets and holds until reset.
- States:
  - IDLE:
    - Combinational mux: cmd=cmd_uart, cmd_rdy=cmd_rdy_uart, clr_cmd_rdy_uart=clr_cmd_rdy.
    - On start_tour: assert tour_go for exactly 1 cycle, indx←0, go to SOLVE.
  - SOLVE: wait for tour_done; next cycle go to VERT. UART mux disabled: cmd_rdy=0, clr_cmd_rdy_uart=0.
  - VERT:
    - cmd is registered from the decode of move; cmd_rdy=1 from the cycle after entry.
    - cmd_rdy stays high until the cycle clr_cmd_rdy=1 is sampled; it drops the following cycle; then go to WAIT_V.
  - WAIT_V: on send_resp go to HORZ.
  - HORZ: same handshake as VERT, using the horizontal leg; then go to WAIT_H.
  - WAIT_H: on send_resp:
    - If indx==NUM_MOVES-1: go to IDLE, indx←0.
    - Else indx←indx+1 and go to VERT.
- indx is stable from VERT entry through WAIT_H exit; move is treated as combinational from indx and sampled on VERT/HORZ entry.
- resp=8'hA5 while in VERT..WAIT_H for indx<NUM_MOVES-1; it is 8'h5A during the final move's WAIT_H and in IDLE/SOLVE.
- start_tour outside IDLE is ignored; cmd_rdy_uart outside IDLE is ignored and not cleared.
- send_resp or clr_cmd_rdy arriving in a state not waiting for it is ignored.
- clr_cmd_rdy and send_resp may assert in the same cycle in VERT/HORZ: accept the clear, go to WAIT state; that send_resp is not counted.
- tour_done never arriving: remain in SOLVE. No timeout; only rst_n recovers.
- rst_n asserted mid-tour: all state returns to reset values immediately; no partial command is retained.

Test Plan:
- IDLE passthrough: cmd_uart=16'h2003, cmd_rdy_uart=1, clr_cmd_rdy=1 → cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_uart=1 in the same cycle; tour_go stays 0.
- Tour launch: start_tour pulse → tour_go high exactly 1 cycle, indx=0, cmd_rdy=0 until tour_done.
- Move decode: indx0 move=8'h04 → first command 16'h2001 (N1, OP_MOVE), then after clear+send_resp 16'h33F2 (W2, OP_FANFARE).
- Full tour: 24 moves with prompt clear/send_resp.
  - Exactly 48 cmd_rdy assertions.
  - indx steps 0..23.
  - resp=A5 until the final leg, then 5A; return to IDLE with indx=0.
- Boundary: move=8'h00 at indx 5 → two commands with squares 0, err=1 and held; start_tour during VERT is ignored.
- Reset mid-tour: rst_n low while in WAIT_V at indx 10 → cmd_rdy=0, indx=0, state IDLE, resp=8'h5A on the next edge.
